// File: rtl/bs_dispatch_ctrl.sv
// Dispatch controller for a Black-Scholes engine array: round-robin engine
// starts under an in-flight cap, operand refill requests, drain and statistics.
module bs_dispatch_ctrl #(
    parameter int NUM_ENGINES  = 20,
    parameter int MAX_INFLIGHT = NUM_ENGINES,
    parameter int CNT_W        = 32,
    parameter int JOB_W        = 16
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               out_of_data,
    input  logic [NUM_ENGINES-1:0]             reg_valid,
    input  logic [NUM_ENGINES-1:0]             eng_idle,
    input  logic [NUM_ENGINES-1:0]             eng_done,
    output logic [NUM_ENGINES-1:0]             eng_start,
    output logic [NUM_ENGINES-1:0]             reg_fetch,
    output logic [NUM_ENGINES-1:0]             inflight,
    output logic [$clog2(NUM_ENGINES+1)-1:0]   inflight_cnt,
    output logic [CNT_W-1:0]                   cycle_count,
    output logic [JOB_W-1:0]                   jobs_issued,
    output logic [JOB_W-1:0]                   jobs_done,
    output logic                               busy,
    output logic                               round_done,
    output logic                               err_spurious
);

    localparam int IC_W  = $clog2(NUM_ENGINES + 1);
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state, state_n;
    logic [PTR_W-1:0]         ptr, ptr_n, off_sel;
    logic [PTR_W:0]           ptr_sum;
    logic [NUM_ENGINES-1:0]   inflight_n, start_n, cand, cand_rot, oh_rot, grant_oh, valid_done;
    logic [2*NUM_ENGINES-1:0] cand_dbl, oh_dbl;
    logic [CNT_W-1:0]         cycle_n;
    logic [JOB_W-1:0]         issued_n, done_n;
    logic [JOB_W:0]           done_sum;
    logic [IC_W-1:0]          done_cnt;
    logic                     err_n, found, grant_vld;

    assign valid_done = eng_done & inflight;

    always_comb begin
        inflight_cnt = '0;
        done_cnt     = '0;
        for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
            inflight_cnt = inflight_cnt + IC_W'(inflight[i]);
            done_cnt     = done_cnt + IC_W'(valid_done[i]);
        end
    end

    // Round-robin search: rotate candidates so the pointer lands on bit 0,
    // pick the lowest set bit, then rotate the one-hot back.
    always_comb begin
        cand     = reg_valid & eng_idle & ~inflight;
        cand_dbl = {cand, cand} >> ptr;
        cand_rot = cand_dbl[NUM_ENGINES-1:0];
        oh_rot   = '0;
        off_sel  = '0;
        found    = 1'b0;
        for (int unsigned off = 0; off < NUM_ENGINES; off++) begin
            if (!found && cand_rot[off]) begin
                oh_rot[off] = 1'b1;
                off_sel     = PTR_W'(off);
                found       = 1'b1;
            end
        end
        oh_dbl    = {oh_rot, oh_rot} << ptr;
        grant_vld = (state == RUN) && !abort && found &&
                    (inflight_cnt < IC_W'(MAX_INFLIGHT));
        grant_oh  = grant_vld ? oh_dbl[2*NUM_ENGINES-1:NUM_ENGINES] : '0;
        ptr_sum   = {1'b0, ptr} + {1'b0, off_sel} + (PTR_W+1)'(1);
        if (ptr_sum >= (PTR_W+1)'(NUM_ENGINES)) begin
            ptr_sum = ptr_sum - (PTR_W+1)'(NUM_ENGINES);
        end
    end

    assign done_sum   = {1'b0, jobs_done} + (JOB_W+1)'(done_cnt);
    assign reg_fetch  = (state == RUN && !out_of_data) ? ~reg_valid : '0;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign round_done = (state == DONE) && !abort;

    always_comb begin
        state_n    = state;
        inflight_n = inflight;
        ptr_n      = ptr;
        start_n    = '0;
        cycle_n    = cycle_count;
        issued_n   = jobs_issued;
        done_n     = jobs_done;
        err_n      = err_spurious;
        if (state == IDLE) begin
            if (start) begin
                state_n    = RUN;
                inflight_n = '0;
                ptr_n      = '0;
                cycle_n    = '0;
                issued_n   = '0;
                done_n     = '0;
                err_n      = 1'b0;
            end
        end else if (abort) begin
            state_n    = IDLE;
            inflight_n = '0;
        end else begin
            inflight_n = (inflight & ~eng_done) | grant_oh;
            done_n     = done_sum[JOB_W] ? '1 : done_sum[JOB_W-1:0];
            if ((eng_done & ~inflight) != '0) begin
                err_n = 1'b1;
            end
            if (state != DONE && cycle_count != '1) begin
                cycle_n = cycle_count + CNT_W'(1);
            end
            if (grant_vld) begin
                start_n = grant_oh;
                ptr_n   = ptr_sum[PTR_W-1:0];
                if (jobs_issued != '1) begin
                    issued_n = jobs_issued + JOB_W'(1);
                end
            end
            case (state)
                RUN:     if (out_of_data && reg_valid == '0) state_n = DRAIN;
                DRAIN:   if (inflight == '0 && eng_idle == '1 && eng_start == '0) state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            inflight     <= '0;
            ptr          <= '0;
            eng_start    <= '0;
            cycle_count  <= '0;
            jobs_issued  <= '0;
            jobs_done    <= '0;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_n;
            inflight     <= inflight_n;
            ptr          <= ptr_n;
            eng_start    <= start_n;
            cycle_count  <= cycle_n;
            jobs_issued  <= issued_n;
            jobs_done    <= done_n;
            err_spurious <= err_n;
        end
    end

endmodule

// File: tb/tb_bs_dispatch_ctrl.sv
// Randomized bench for bs_dispatch_ctrl: emulated engines and data controller,
// compared every cycle against a rule-level reference model.
module tb_bs_dispatch_ctrl;

    localparam int N    = 4;
    localparam int MAXI = 2;
    localparam int IC_W = $clog2(N + 1);
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

    logic           clock = 1'b0;
    logic           reset_n, start, abort, out_of_data;
    logic [N-1:0]   reg_valid, eng_idle, eng_done;
    logic [N-1:0]   eng_start, reg_fetch, inflight;
    logic [IC_W-1:0] inflight_cnt;
    logic [31:0]    cycle_count;
    logic [15:0]    jobs_issued, jobs_done;
    logic           busy, round_done, err_spurious;

    logic [N-1:0]   eng_start_4, reg_fetch_4, inflight_4;
    logic [IC_W-1:0] inflight_cnt_4;
    logic [31:0]    cycle_count_4;
    logic [15:0]    jobs_issued_4, jobs_done_4;
    logic           busy_4, round_done_4, err_spurious_4;

    always #5 clock = ~clock;

    bs_dispatch_ctrl #(.NUM_ENGINES(N), .MAX_INFLIGHT(MAXI), .CNT_W(32), .JOB_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .out_of_data(out_of_data), .reg_valid(reg_valid), .eng_idle(eng_idle),
        .eng_done(eng_done), .eng_start(eng_start), .reg_fetch(reg_fetch),
        .inflight(inflight), .inflight_cnt(inflight_cnt), .cycle_count(cycle_count),
        .jobs_issued(jobs_issued), .jobs_done(jobs_done), .busy(busy),
        .round_done(round_done), .err_spurious(err_spurious)
    );

    // Uncapped instance sharing the same inputs, used for the pure round-robin order.
    bs_dispatch_ctrl #(.NUM_ENGINES(N), .MAX_INFLIGHT(N), .CNT_W(32), .JOB_W(16)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .out_of_data(out_of_data), .reg_valid(reg_valid), .eng_idle(eng_idle),
        .eng_done(eng_done), .eng_start(eng_start_4), .reg_fetch(reg_fetch_4),
        .inflight(inflight_4), .inflight_cnt(inflight_cnt_4), .cycle_count(cycle_count_4),
        .jobs_issued(jobs_issued_4), .jobs_done(jobs_done_4), .busy(busy_4),
        .round_done(round_done_4), .err_spurious(err_spurious_4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int           m_phase, m_ptr, m_pend, m_cyc, m_iss, m_don;
    logic [N-1:0] m_infl;
    logic         m_err;

    // Engine / data-controller emulation state
    logic [N-1:0] em_valid, em_busy, em_done;
    int           em_timer[N];
    int           em_rf[N];
    int           remaining, lat_lo, lat_hi, rd_seen;
    bit           never_finish;
    bit           ov_valid_en, ov_ood_en, start_req, abort_req;
    logic [N-1:0] ov_valid, inj_done;
    logic         ov_ood;

    function automatic logic bit_at(input logic [N-1:0] v, input int e);
        logic [N-1:0] t;
        t = v >> e;
        return t[0];
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_ptr = 0; m_pend = -1;
        m_cyc = 0; m_iss = 0; m_don = 0; m_infl = '0; m_err = 1'b0;
    endtask

    task automatic emu_clear();
        em_valid = '0; em_busy = '0; em_done = '0; remaining = 0;
        for (int i = 0; i < N; i++) begin
            em_timer[i] = 0;
            em_rf[i]    = 0;
        end
        inj_done = '0; start_req = 0; abort_req = 0;
        ov_valid_en = 0; ov_ood_en = 0; ov_valid = '0; ov_ood = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] exp_start, exp_fetch, old_infl, g_mask;
        int           g;
        exp_start = (m_pend >= 0) ? (N'(1) << m_pend) : '0;
        exp_fetch = (m_phase == PH_RUN && !out_of_data) ? ~reg_valid : '0;
        check("eng_start", eng_start, exp_start);
        check("reg_fetch", reg_fetch, exp_fetch);
        check("inflight", inflight, m_infl);
        check("inflight_cnt", inflight_cnt, $countones(m_infl));
        check("cap", inflight_cnt <= IC_W'(MAXI), 1'b1);
        check("cycle_count", cycle_count, m_cyc);
        check("jobs_issued", jobs_issued, m_iss);
        check("jobs_done", jobs_done, m_don);
        check("busy", busy, m_phase == PH_RUN || m_phase == PH_DRAIN);
        check("round_done", round_done, m_phase == PH_DONE && !abort);
        check("err_spurious", err_spurious, m_err);

        if (m_phase == PH_IDLE) begin
            m_pend = -1;
            if (start) begin
                m_phase = PH_RUN; m_infl = '0; m_ptr = 0;
                m_cyc = 0; m_iss = 0; m_don = 0; m_err = 1'b0;
            end
        end else if (abort) begin
            m_phase = PH_IDLE; m_infl = '0; m_pend = -1;
        end else begin
            old_infl = m_infl;
            g = -1;
            if (m_phase == PH_RUN && $countones(old_infl) < MAXI) begin
                for (int k = 0; k < N; k++) begin
                    int e;
                    e = (m_ptr + k) % N;
                    if (g < 0 && bit_at(reg_valid, e) && bit_at(eng_idle, e) && !bit_at(old_infl, e))
                        g = e;
                end
            end
            m_don = m_don + $countones(eng_done & old_infl);
            if ((eng_done & ~old_infl) != '0) m_err = 1'b1;
            if (m_phase == PH_RUN || m_phase == PH_DRAIN) m_cyc++;
            g_mask = (g >= 0) ? (N'(1) << g) : '0;
            m_infl = (old_infl & ~eng_done) | g_mask;
            case (m_phase)
                PH_RUN:   if (out_of_data && reg_valid == '0) m_phase = PH_DRAIN;
                PH_DRAIN: if (old_infl == '0 && eng_idle == '1 && m_pend < 0) m_phase = PH_DONE;
                default:  m_phase = PH_IDLE;
            endcase
            m_pend = g;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                m_iss++;
            end
        end
    endtask

    task automatic emu_update();
        logic [N-1:0] fin;
        fin     = em_done;
        em_done = '0;
        for (int i = 0; i < N; i++) begin
            if (fin[i]) begin
                em_busy[i] = 1'b0;
            end else if (em_busy[i] && em_timer[i] > 0) begin
                em_timer[i]--;
                if (em_timer[i] == 0) em_done[i] = 1'b1;
            end
            if (eng_start[i]) begin
                em_busy[i]  = 1'b1;
                em_timer[i] = never_finish ? 0 : int'($urandom_range(lat_hi, lat_lo));
                em_valid[i] = 1'b0;
            end
            if (em_rf[i] > 0) begin
                em_rf[i]--;
                if (em_rf[i] == 0) em_valid[i] = 1'b1;
            end else if (reg_fetch[i] && !em_valid[i] && remaining > 0) begin
                remaining--;
                em_rf[i] = int'($urandom_range(3, 1));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        reg_valid   = ov_valid_en ? ov_valid : em_valid;
        out_of_data = ov_ood_en ? ov_ood : (remaining == 0);
        eng_idle    = ~em_busy;
        eng_done    = em_done | inj_done;
        start       = start_req;
        abort       = abort_req;
        #1;
        if (round_done) rd_seen++;
        model_step();
        emu_update();
        inj_done  = '0;
        start_req = 0;
        abort_req = 0;
    endtask

    task automatic wait_quiet();
        for (int w = 0; w < 200 && (em_busy != '0 || em_done != '0); w++) cycle();
        check("quiet", em_busy, '0);
    endtask

    task automatic reset_checks(input string p);
        check({p, "_eng_start"}, eng_start, '0);
        check({p, "_reg_fetch"}, reg_fetch, '0);
        check({p, "_inflight"}, inflight, '0);
        check({p, "_inflight_cnt"}, inflight_cnt, '0);
        check({p, "_cycle_count"}, cycle_count, '0);
        check({p, "_jobs_issued"}, jobs_issued, '0);
        check({p, "_jobs_done"}, jobs_done, '0);
        check({p, "_busy"}, busy, 1'b0);
        check({p, "_round_done"}, round_done, 1'b0);
        check({p, "_err"}, err_spurious, 1'b0);
    endtask

    task automatic run_round(input int d, input int abort_at, input int spur_at,
                             input logic [N-1:0] spur_mask, input int st_at);
        int k;
        bit aborted;
        wait_quiet();
        for (int i = 0; i < N; i++) em_rf[i] = 0;
        em_valid  = (d >= N) ? '1 : ((N'(1) << d) - N'(1));
        remaining = (d >= N) ? d - N : 0;
        rd_seen   = 0;
        aborted   = 0;
        start_req = 1;
        cycle();
        k = 0;
        do begin
            if (k == abort_at) begin
                abort_req = 1;
                aborted   = 1;
            end
            if (k == st_at) start_req = 1;
            if (k == spur_at && (spur_mask & (m_infl | em_busy | em_done)) == '0)
                inj_done = spur_mask;
            cycle();
            k++;
        end while (m_phase != PH_IDLE && k < 600);
        cycle();
        check("round_end_busy", busy, 1'b0);
        if (aborted) begin
            check("abort_no_round_done", rd_seen, 0);
        end else begin
            check("issued_total", jobs_issued, d);
            check("done_total", jobs_done, d);
            check("round_done_once", rd_seen, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] rr[6];
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_of_data = 1'b0;
        reg_valid = '0; eng_idle = '1; eng_done = '0;
        never_finish = 0; lat_lo = 1; lat_hi = 1; rd_seen = 0;
        model_reset();
        emu_clear();
        #13;
        reset_checks("reset");
        @(negedge clock);
        reset_n = 1'b1;
        cycle();
        cycle();

        // Minimum round with no data plus a spurious completion on engine 2
        run_round(0, -1, 0, 4'b0100, -1);
        check("min_cycle_count", cycle_count, 2);
        check("spur_sticky", err_spurious, 1'b1);
        check("spur_jobs_done", jobs_done, 0);

        // Six jobs, drain, err cleared by the new start
        lat_lo = 4; lat_hi = 10;
        run_round(6, -1, -1, '0, -1);
        check("err_cleared", err_spurious, 1'b0);

        // Concurrency cap with fixed latency
        lat_lo = 10; lat_hi = 10;
        run_round(10, -1, -1, '0, -1);

        for (int r = 0; r < 20; r++) begin
            int ab, sp, st, dd;
            lat_lo = int'($urandom_range(4, 1));
            lat_hi = lat_lo + int'($urandom_range(12, 0));
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(25, 0)) : -1;
            sp = ($urandom_range(4, 0) == 0) ? int'($urandom_range(15, 0)) : -1;
            st = ($urandom_range(2, 0) == 0) ? int'($urandom_range(10, 1)) : -1;
            dd = int'($urandom_range(14, 0));
            run_round(dd, ab, sp, N'(1) << $urandom_range(N - 1, 0), st);
        end

        // Round-robin order on the uncapped instance; engines never finish
        wait_quiet();
        never_finish = 1;
        for (int i = 0; i < N; i++) em_rf[i] = 0;
        em_valid  = '1;
        remaining = 0;
        start_req = 1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            rr[k] = eng_start_4;
        end
        check("rr_c0", rr[0], 4'b0000);
        check("rr_c1", rr[1], 4'b0001);
        check("rr_c2", rr[2], 4'b0010);
        check("rr_c3", rr[3], 4'b0100);
        check("rr_c4", rr[4], 4'b1000);
        check("rr_c5", rr[5], 4'b0000);
        check("rr_issued", jobs_issued_4, 4);

        // Refill requests follow reg_valid and out_of_data in the same cycle
        ov_valid_en = 1; ov_valid = 4'b1010; ov_ood_en = 1; ov_ood = 1'b0;
        cycle();
        check("fetch_0101", reg_fetch, 4'b0101);
        ov_ood = 1'b1;
        cycle();
        check("fetch_ood", reg_fetch, 4'b0000);
        ov_valid_en = 0; ov_ood_en = 0;

        // Abort with two engines in flight
        check("pre_abort_inflight", inflight, 4'b0011);
        rd_seen   = 0;
        abort_req = 1;
        cycle();
        cycle();
        check("abort_busy", busy, 1'b0);
        check("abort_inflight", inflight, 4'b0000);
        check("abort_round_done", rd_seen, 0);
        never_finish = 0;
        em_busy = '0; em_done = '0; em_valid = '0;
        cycle();

        // Asynchronous reset in the middle of a run
        lat_lo = 20; lat_hi = 20;
        em_valid  = '1;
        remaining = 4;
        start_req = 1;
        cycle();
        repeat (5) cycle();
        check("pre_reset_busy", busy, 1'b1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 reset_checks("areset");
        model_reset();
        emu_clear();
        @(negedge clock);
        reset_n = 1'b1;

        lat_lo = 2; lat_hi = 6;
        run_round(5, -1, -1, '0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bs_dispatch_ctrl.md
# bs_dispatch_ctrl

Parametrised dispatch controller for an array of Black-Scholes pricing engines. It starts engines one per cycle in round-robin order, caps concurrent engines at a configurable limit, and requests operand-register refills from the data controller. It tracks every in-flight job, drains the array once input data is exhausted, and reports cycle, dispatch and completion statistics per round. It sits between the data controller (operand registers) and the engine array.

## Interface
- `NUM_ENGINES`, default 20: number of engines/operand registers (1..64).
- `MAX_INFLIGHT`, default `NUM_ENGINES`: maximum engines running at once (1..`NUM_ENGINES`).
- `CNT_W`, default 32: cycle counter width.
- `JOB_W`, default 16: dispatched/completed job counter width.
- `clock` in 1: rising-edge clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a round (honoured only in IDLE).
- `abort` in 1: synchronous abort of the round.
- `out_of_data` in 1: data controller has no further operands.
- `reg_valid` in `NUM_ENGINES`: operand register i holds unused data.
- `eng_idle` in `NUM_ENGINES`: engine i idle.
- `eng_done` in `NUM_ENGINES`: one-cycle completion pulse from engine i.
- `eng_start` out `NUM_ENGINES`: one-hot (or zero) start pulse.
- `reg_fetch` out `NUM_ENGINES`: refill request for register i.
- `inflight` out `NUM_ENGINES`: engines currently running.
- `inflight_cnt` out `$clog2(NUM_ENGINES+1)`: population count of `inflight`.
- `cycle_count` out `CNT_W`: cycles spent in RUN+DRAIN this round.
- `jobs_issued`, `jobs_done` out `JOB_W`: round statistics.
- `busy` out 1: state is RUN or DRAIN.
- `round_done` out 1: one-cycle pulse at end of round.
- `err_spurious` out 1: sticky; `eng_done[i]` seen while `inflight[i]`=0.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset: IDLE, all outputs 0, RR pointer 0.
- IDLE:
  - `start` clears `cycle_count`, `jobs_issued`, `jobs_done`, `err_spurious`, `inflight` and the RR pointer, then goes to RUN.
- RUN:
  - Candidates are `reg_valid & eng_idle & ~inflight`.
  - If a candidate exists and `inflight_cnt` < `MAX_INFLIGHT`, grant the first candidate at or after the RR pointer, modulo `NUM_ENGINES`.
  - Grant effects: registered `eng_start[i]`, set `inflight[i]`, pointer becomes i+1 (wraps `NUM_ENGINES`-1 to 0), `jobs_issued`+1.
  - At most one grant per cycle.
- `reg_fetch[i]` = RUN & ~`reg_valid[i]` & ~`out_of_data` (level, combinational). It is 0 in all other states.
- RUN goes to DRAIN when `out_of_data` and `reg_valid`==0.
- DRAIN: no grants. Goes to DONE when `inflight`==0, `eng_idle` is all ones, and no `eng_start` pulse is pending.
- DONE: `round_done`=1 for one cycle, then IDLE. Counters hold until the next `start`.
- `eng_done[i]` in any non-IDLE state:
  - If `inflight[i]`: clear it and increment `jobs_done`.
  - Otherwise: set `err_spurious`; no counter change.
- Same cycle, done on engine j and grant on engine k: both apply, so `inflight_cnt` is unchanged.
- Done and grant on the same engine in one cycle cannot occur, because a grant requires `inflight[i]`=0.
- `cycle_count` increments every RUN/DRAIN cycle and saturates at all-ones. The job counters also saturate.
- `abort` takes priority in RUN/DRAIN/DONE:
  - Next state IDLE; `inflight` cleared; pending `eng_start` suppressed; no `round_done`.
  - Counters frozen. `abort` in IDLE is ignored.
- `start` outside IDLE is ignored.
- `reset_n` low mid-round returns everything to reset values immediately, with no pulses.

## Timing
- Grant decision in cycle t; `eng_start[i]` high in cycle t+1 only. `inflight[i]` is visible from t+1.
- `inflight` clears on the edge after `eng_done` is sampled. The freed slot is usable for a grant in the next cycle.
- `start` at edge t: `busy`=1 from t+1. First possible `eng_start` at t+2.
- `round_done` and `busy`=0 occur in the same cycle (DONE). `cycle_count` excludes the DONE cycle.
- Minimum round with empty data and `out_of_data`=1: IDLE, RUN, DRAIN, DONE, IDLE, with `cycle_count`=2.

## Test plan
Bench parameters: `NUM_ENGINES`=4, `MAX_INFLIGHT`=2 unless noted.
- Round-robin: all `reg_valid`/`eng_idle`=1, engines never finish, `MAX_INFLIGHT`=4 -> `eng_start` 0001, 0010, 0100, 1000 on consecutive cycles; `jobs_issued`=4.
- Concurrency cap: all ready, engines done 10 cycles after start -> `inflight_cnt` never exceeds 2. A new grant follows each done by exactly 1 cycle.
- Drain and done: 6 jobs total, then `out_of_data`=1 -> DRAIN until the last `eng_done`. `round_done` pulses once; `jobs_issued`=`jobs_done`=6; `err_spurious`=0.
- Spurious done: `eng_done`=0100 while `inflight`=0000 -> `err_spurious`=1 sticky, `jobs_done` unchanged, then cleared by the next `start`.
- Abort and reset: `abort` with `inflight`=0011 -> IDLE next cycle, `inflight`=0, no `round_done`. `reset_n` low mid-RUN -> all outputs 0 asynchronously.
- Refill: `reg_valid`=1010, `out_of_data`=0 in RUN -> `reg_fetch`=0101. Raising `out_of_data` -> `reg_fetch`=0000 in the same cycle.
